// File: rtl/osd_reg_initiator.sv
// osd_reg_initiator: turns one local 16-bit register read/write into an OSD REG request packet and returns the matching response; OSD_REG_INIT_TIMEOUT_EN enables a response timeout.
// Latency: first flit the cycle after the req handshake, rsp_valid the cycle after the last response flit; flits hold while !debug_out_ready, debug_in stalls only while a result waits on rsp_ready.
package osd_dii_pkg;
    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;
endpackage

module osd_reg_initiator
    import osd_dii_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  id,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_dest,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_err,
    output logic [15:0] rsp_rdata,
    output dii_flit     debug_out,
    input  logic        debug_out_ready,
    input  dii_flit     debug_in,
    output logic        debug_in_ready
);

    localparam logic [3:0] SUB_REQ_RD = 4'b0000;
    localparam logic [3:0] SUB_REQ_WR = 4'b1000;
    localparam logic [3:0] SUB_RD_OK  = 4'b0000;
    localparam logic [3:0] SUB_RD_ERR = 4'b1100;

    typedef enum logic [3:0] {
        IDLE, TX_DEST, TX_SRC, TX_TYPE, TX_ADDR, TX_WDATA,
        RX_DEST, RX_SRC, RX_TYPE, RX_DATA, RX_DROP, RESP
    } state_t;

    state_t      state;
    logic        wr_q;
    logic [15:0] dest_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        in_pkt;

    logic        in_acc;
    logic        out_acc;
    logic        busy_next;
    logic [15:0] src_word;
    logic [3:0]  sub;
    logic        type_reg;
    logic        rx_done;
    logic        rx_err;
    state_t      rx_fail;
    state_t      rx_entry;

    always_comb begin
        src_word  = {6'h0, id};
        in_acc    = debug_in.valid & debug_in_ready;
        out_acc   = debug_out.valid & debug_out_ready;
        // in_pkt tracks packet framing on debug_in in every state, so a
        // half-received packet is never mistaken for the start of a response
        busy_next = in_acc ? !debug_in.last : in_pkt;
        rx_entry  = busy_next ? RX_DROP : RX_DEST;
        sub       = debug_in.data[13:10];
        type_reg  = (debug_in.data[15:14] == 2'b00);
        // a mismatching flit that already ends its packet leaves nothing to drop
        rx_fail   = debug_in.last ? RX_DEST : RX_DROP;
        rx_done   = 1'b0;
        rx_err    = 1'b0;
        if (in_acc && debug_in.last) begin
            if (state == RX_DATA) begin
                rx_done = 1'b1;
            end else if (state == RX_TYPE && type_reg) begin
                if (wr_q) begin
                    rx_done = (sub[3:1] == 3'b111);
                    rx_err  = sub[0];
                end else begin
                    rx_done = (sub == SUB_RD_ERR);
                    rx_err  = 1'b1;
                end
            end
        end
    end

`ifdef OSD_REG_INIT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_cnt;
    logic          rx_wait;

    always_comb begin
        rx_wait = (state == RX_DEST) || (state == RX_SRC) || (state == RX_TYPE) ||
                  (state == RX_DATA) || (state == RX_DROP);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            wr_q           <= 1'b0;
            dest_q         <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            in_pkt         <= 1'b0;
            req_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_err        <= 1'b0;
            rsp_rdata      <= '0;
            debug_out      <= '0;
            debug_in_ready <= 1'b1;
`ifdef OSD_REG_INIT_TIMEOUT_EN
            tmo_cnt        <= '0;
`endif
        end else begin
            if (in_acc) begin
                in_pkt <= !debug_in.last;
            end
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        wr_q            <= req_write;
                        dest_q          <= req_dest;
                        addr_q          <= req_addr;
                        wdata_q         <= req_wdata;
                        req_ready       <= 1'b0;
                        debug_out.valid <= 1'b1;
                        debug_out.last  <= 1'b0;
                        debug_out.data  <= req_dest;
                        state           <= TX_DEST;
                    end
                end
                TX_DEST: if (out_acc) begin
                    debug_out.data <= src_word;
                    state          <= TX_SRC;
                end
                TX_SRC: if (out_acc) begin
                    debug_out.data <= {2'b00, (wr_q ? SUB_REQ_WR : SUB_REQ_RD), 10'h0};
                    state          <= TX_TYPE;
                end
                TX_TYPE: if (out_acc) begin
                    debug_out.data <= addr_q;
                    debug_out.last <= !wr_q;
                    state          <= TX_ADDR;
                end
                TX_ADDR: if (out_acc) begin
                    if (wr_q) begin
                        debug_out.data <= wdata_q;
                        debug_out.last <= 1'b1;
                        state          <= TX_WDATA;
                    end else begin
                        debug_out <= '0;
                        state     <= rx_entry;
                    end
                end
                TX_WDATA: if (out_acc) begin
                    debug_out <= '0;
                    state     <= rx_entry;
                end
                RX_DEST: if (in_acc) begin
                    state <= (debug_in.data == src_word && !debug_in.last) ? RX_SRC : rx_fail;
                end
                RX_SRC: if (in_acc) begin
                    state <= (debug_in.data == dest_q && !debug_in.last) ? RX_TYPE : rx_fail;
                end
                RX_TYPE: if (in_acc) begin
                    if (rx_done) begin
                        state          <= RESP;
                        rsp_valid      <= 1'b1;
                        rsp_err        <= rx_err;
                        rsp_rdata      <= '0;
                        debug_in_ready <= 1'b0;
                    end else if (type_reg && !wr_q && sub == SUB_RD_OK && !debug_in.last) begin
                        state <= RX_DATA;
                    end else begin
                        state <= rx_fail;
                    end
                end
                RX_DATA: if (in_acc) begin
                    if (rx_done) begin
                        state          <= RESP;
                        rsp_valid      <= 1'b1;
                        rsp_err        <= 1'b0;
                        rsp_rdata      <= debug_in.data;
                        debug_in_ready <= 1'b0;
                    end else begin
                        state <= RX_DROP;
                    end
                end
                RX_DROP: if (in_acc && debug_in.last) begin
                    state <= RX_DEST;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid      <= 1'b0;
                    rsp_err        <= 1'b0;
                    rsp_rdata      <= '0;
                    req_ready      <= 1'b1;
                    debug_in_ready <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
`ifdef OSD_REG_INIT_TIMEOUT_EN
            // a response completing in the expiry cycle still wins over the timeout
            if (rx_wait) begin
                tmo_cnt <= tmo_cnt + 1'b1;
                if (tmo_cnt == TMO_LAST && !rx_done) begin
                    state          <= RESP;
                    rsp_valid      <= 1'b1;
                    rsp_err        <= 1'b1;
                    rsp_rdata      <= '0;
                    debug_in_ready <= 1'b0;
                end
            end else begin
                tmo_cnt <= '0;
            end
`endif
        end
    end

endmodule
